// File: rtl/pwm_multi_if.sv
// pwm_multi register bus: address, write data, write strobe and
// combinational readback shared by the CPU side and the peripheral.
interface pwm_multi_if;
    logic [3:0]  addr;
    logic [31:0] data_in;
    logic        write_en;
    logic [31:0] data_out;

    modport master (
        output addr,
        output data_in,
        output write_en,
        input  data_out
    );

    modport slave (
        input  addr,
        input  data_in,
        input  write_en,
        output data_out
    );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaled period counter, double-buffered
// period/compare registers swapped at wrap, per-channel polarity.
module pwm_multi #(
    parameter int CHANNELS      = 4,
    parameter int WIDTH         = 8,
    parameter int PRESCALE_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    pwm_multi_if.slave          bus,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_irq
);

    logic                     r_run;
    logic [PRESCALE_BITS-1:0] r_pre;
    logic [WIDTH-1:0]         r_period;
    logic                     r_flag;
    logic [CHANNELS-1:0]      r_pol;
    logic [WIDTH-1:0]         r_cmp     [CHANNELS];
    logic [WIDTH-1:0]         r_per_act;
    logic [WIDTH-1:0]         r_cmp_act [CHANNELS];
    logic [WIDTH-1:0]         r_cnt;
    logic [PRESCALE_BITS-1:0] r_psc;
    logic [CHANNELS-1:0]      r_pwm;

    logic        w_tick;
    logic        w_wrap;
    logic        w_load;
    logic        w_clr;
    logic [31:0] w_rdata;
    logic        w_unused_data;

    assign w_tick = r_run && (r_psc == r_pre);
    assign w_wrap = w_tick && (r_cnt == r_per_act);
    // Active copies track the buffers while stopped, so a start
    // begins with the current buffer values already in effect.
    assign w_load = !r_run || w_wrap;
    assign w_clr  = bus.write_en && (bus.addr == 4'd2) && bus.data_in[0];

    assign w_unused_data = ^bus.data_in;

    assign pwm_out    = r_pwm;
    assign period_irq = r_flag;

    // CPU-written buffer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run    <= 1'b0;
            r_pre    <= '0;
            r_period <= '0;
            r_pol    <= '0;
            for (int n = 0; n < CHANNELS; n++) r_cmp[n] <= '0;
        end else if (bus.write_en) begin
            case (bus.addr)
                4'd0: begin
                    r_run <= bus.data_in[0];
                    r_pre <= bus.data_in[PRESCALE_BITS+7:8];
                end
                4'd1: r_period <= bus.data_in[WIDTH-1:0];
                4'd3: r_pol    <= bus.data_in[CHANNELS-1:0];
                default: begin
                    for (int n = 0; n < CHANNELS; n++)
                        if (int'(bus.addr) == n + 4)
                            r_cmp[n] <= bus.data_in[WIDTH-1:0];
                end
            endcase
        end
    end

    // Sticky wrap flag; a wrap beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst)         r_flag <= 1'b0;
        else if (w_wrap) r_flag <= 1'b1;
        else if (w_clr)  r_flag <= 1'b0;
    end

    // Prescaler and period counter, held at zero while stopped
    always_ff @(posedge clk) begin
        if (rst || !r_run) begin
            r_psc <= '0;
            r_cnt <= '0;
        end else if (w_tick) begin
            r_psc <= '0;
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end else begin
            r_psc <= r_psc + 1'b1;
        end
    end

    // Active period/compare load from buffers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_per_act <= '0;
            for (int n = 0; n < CHANNELS; n++) r_cmp_act[n] <= '0;
        end else if (w_load) begin
            r_per_act <= r_period;
            for (int n = 0; n < CHANNELS; n++) r_cmp_act[n] <= r_cmp[n];
        end
    end

    // Registered compare outputs with polarity
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm <= '0;
        end else begin
            for (int n = 0; n < CHANNELS; n++)
                r_pwm[n] <= r_run ? ((r_cnt < r_cmp_act[n]) ^ r_pol[n])
                                  : r_pol[n];
        end
    end

    // Combinational register readback
    always_comb begin
        w_rdata = '0;
        case (bus.addr)
            4'd0: begin
                w_rdata[0]                   = r_run;
                w_rdata[PRESCALE_BITS+7:8]   = r_pre;
            end
            4'd1: w_rdata[WIDTH-1:0]    = r_period;
            4'd2: w_rdata[0]            = r_flag;
            4'd3: w_rdata[CHANNELS-1:0] = r_pol;
            default: begin
                for (int n = 0; n < CHANNELS; n++)
                    if (int'(bus.addr) == n + 4)
                        w_rdata[WIDTH-1:0] = r_cmp[n];
            end
        endcase
    end

    assign bus.data_out = w_rdata;

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM peripheral: the parametrised successor to the single-channel 8-bit `pwm_ctrl`. It has CHANNELS outputs sharing one WIDTH-bit period counter, a clock prescaler, per-channel polarity, and compare and period registers that are double-buffered and take effect only at the period wrap, so there are no output glitches. A period-wrap flag provides an interrupt request. It sits on the peripheral bus in `tinyQV_top`, alongside the UART and SPI peripherals, and its outputs feed the uo_out / uio output muxes.

## Interface
- CHANNELS, default 4: number of PWM outputs, 1..8.
- WIDTH, default 8: counter, period and compare width, 2..16.
- PRESCALE_BITS, default 8: prescaler divider width, 1..16.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- addr  in  4  register select.
- data_in  in  32  write data.
- write_en  in  1  one-cycle write strobe for the register at addr.
- data_out  out  32  combinational readback of the register at addr.
- pwm_out  out  CHANNELS  registered PWM outputs.
- period_irq  out  1  equals the sticky wrap flag.

## Operation
- Registers (all are "buffer" registers as written by the CPU):
  - 0 CTRL: [0] run, [PRESCALE_BITS+7:8] prescale P.
  - 1 PERIOD: [WIDTH-1:0].
  - 2 STATUS: [0] wrap flag. Writing 1 to bit 0 clears it; writing 0 has no effect.
  - 3 POLARITY: [CHANNELS-1:0]. A 1 inverts that channel.
  - 4+n CMP[n]: [WIDTH-1:0], for n < CHANNELS.
- Unused bits and unmapped addresses read 0. Writes to them are ignored.
- Active registers: per_act and cmp_act[n] drive the counter and compare logic. Neither is directly writable.
- run=0:
  - Prescaler and counter are held at 0.
  - per_act and cmp_act load from their buffer registers every cycle.
  - pwm_out[n] = POLARITY[n].
  - The wrap flag is not set.
- run=1:
  - The prescaler counts 0..P. A tick is asserted on the cycle the prescaler equals P, and the prescaler then returns to 0. With P=0 there is a tick every cycle.
  - On a tick with counter != per_act: counter increments.
  - On a tick with counter == per_act (wrap): counter goes to 0, per_act/cmp_act load from the buffers, and the wrap flag sets.
  - The buffer values captured at a wrap are those held before that edge. A write landing in the wrap cycle takes effect at the next wrap.
- Compare rule: raw[n] = (counter < cmp_act[n]); pwm_out[n] <= raw[n] ^ POLARITY[n].
  - cmp=0 gives a constant low raw value.
  - cmp > per_act gives a constant high raw value.
  - Duty = cmp/(per_act+1), with the comparison done at WIDTH bits, unsigned.
- POLARITY is not buffered; it takes effect on the next output update.
- PERIOD=0: the counter stays 0 and every tick is a wrap.
- STATUS: if a wrap and a clear-write occur in the same cycle, the set wins and the flag stays 1.
- run 1→0 mid-period: the counter resets immediately and outputs go to the inactive level next cycle.
- run 0→1: counting starts from 0 with the current buffer values already active.

## Timing
- Reset values: all registers 0, counter 0, prescaler 0, per_act/cmp_act 0, pwm_out all 0, period_irq 0.
- Writes take effect in the buffer registers at the clock edge where write_en=1.
- data_out reflects addr in the same cycle; a read after a write returns the new value.
- PWM period = (per_act+1)*(P+1) clk cycles.
- pwm_out is registered: it reflects the counter value from one cycle earlier. A wrap on edge k gives new-period outputs after edge k+1.
- The wrap flag and period_irq are high starting the cycle after the wrap edge.
- From a run=1 write to the first counter increment: P+1 cycles.

## Test plan
- Reset, then read all addresses: all 0, pwm_out=0, period_irq=0.
- CHANNELS=4, WIDTH=8, P=0, PERIOD=9, CMP0..3 = 0, 3, 10, 5, then run=1:
  - ch0 is constantly low.
  - ch1 is high for 3 of 10 cycles.
  - ch2 is constantly high.
  - ch3 is high for 5 of 10 cycles.
  - period_irq rises 10 cycles after counting starts.
- P=3, PERIOD=4, CMP0=2: each output period is 20 cycles with 8 cycles high. Then set POLARITY=1: 12 cycles high.
- Mid-period write CMP0=4 (old value 1): the current period still has 1 tick high; the next period has 4 ticks high. A write in the exact wrap cycle is deferred one more period.
- Wrap flag set plus a same-cycle STATUS write of 1: the flag stays 1. A later write of 1 clears it; a write of 0 leaves it set.
- rst asserted mid-period with run=1: on the next cycle every output and register is 0 and counting stops. PERIOD=0 with CMP0=1: ch0 is constantly high and the wrap flag sets on the first tick.
